// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths and FSM encoding.
package fetch_unit_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory read bus and decode-side instruction bus of the fetch stage.
// mem: req held with a stable addr until a cycle with ack=1 completes the read.
// instr: a word transfers on any cycle where valid & ready; valid never waits on ready.
interface fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_pc,
    input  mem_ack, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_pc,
    output mem_ack, mem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// Prefetch buffer: power-of-two circular FIFO; flush beats push and pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && (cnt_q != '0);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PTR_W'(1);
      if (do_pop)  rd_d = rd_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory read at a time, tagged words into a
// prefetch buffer, redirects forwarded to the PC and all pending work discarded.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_count,
  output logic              pc_inc,
  output logic              pc_we,
  output logic [ADDR_W-1:0] pc_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  fetch_unit_if.master      bus,
  output fetch_state_e      state_o
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W+DATA_W-1:0] head;
  logic              ack, issue, push, pop, valid;

  // Acks are only meaningful while a request is actually outstanding.
  assign ack   = bus.mem_ack && mem_req_q;
  assign issue = (state_q == IDLE) && !redirect_valid && (count < CNT_W'(DEPTH));
  assign push  = (state_q == REQ) && ack && !redirect_valid;
  assign valid = (count != '0);
  assign pop   = valid && bus.instr_ready;

  assign pc_inc  = issue && !rst;
  assign pc_we   = redirect_valid;
  assign pc_data = redirect_addr;

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_count;
        end
      end
      REQ: begin
        if (ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end else if (redirect_valid) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(ADDR_W + DATA_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i ({mem_addr_q, bus.mem_rdata}),
    .rdata_o (head),
    .count_o (count)
  );

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr_valid = valid;
  assign bus.instr       = valid ? head[DATA_W-1:0] : '0;
  assign bus.instr_pc    = valid ? head[ADDR_W+DATA_W-1:DATA_W] : '0;
  assign state_o         = state_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle tables for streaming/backpressure, hand sequences for
// wait states, redirects and mid-request reset. Memory returns ~addr.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  pc_count, pc_data, redirect_addr;
  logic         pc_inc, pc_we, redirect_valid;
  fetch_state_e state;
  int           mem_delay = 0;
  int           wait_cnt;
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .pc_count       (pc_count),
    .pc_inc         (pc_inc),
    .pc_we          (pc_we),
    .pc_data        (pc_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .bus            (bus.master),
    .state_o        (state)
  );

  // PC block and memory environment models.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pc_count <= '0;
    else if (pc_we)  pc_count <= pc_data;
    else if (pc_inc) pc_count <= pc_count + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             wait_cnt <= 0;
    else if (bus.mem_req && !bus.mem_ack) wait_cnt <= wait_cnt + 1;
    else                                 wait_cnt <= 0;
  end

  assign bus.mem_ack   = bus.mem_req && (wait_cnt >= mem_delay);
  assign bus.mem_rdata = ~bus.mem_addr;

  typedef struct {
    logic        rst;
    logic        ready;
    logic        exp_inc;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_pc;
    logic [15:0] exp_instr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic rdy, logic inc, logic req, logic [15:0] a,
                              logic v, logic [15:0] p, logic [15:0] ins);
    vec_t t;
    t.rst = r; t.ready = rdy; t.exp_inc = inc; t.exp_req = req; t.exp_addr = a;
    t.exp_valid = v; t.exp_pc = p; t.exp_instr = ins;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(vec_t v, int idx);
    @(negedge clk);
    rst = v.rst;
    bus.instr_ready = v.ready;
    #1;
    chk($sformatf("vec%0d pc_inc", idx), 32'(pc_inc), 32'(v.exp_inc));
    chk($sformatf("vec%0d mem_req", idx), 32'(bus.mem_req), 32'(v.exp_req));
    if (v.exp_req || v.rst)
      chk($sformatf("vec%0d mem_addr", idx), 32'(bus.mem_addr), 32'(v.exp_addr));
    chk($sformatf("vec%0d instr_valid", idx), 32'(bus.instr_valid), 32'(v.exp_valid));
    if (v.exp_valid || v.rst) begin
      chk($sformatf("vec%0d instr_pc", idx), 32'(bus.instr_pc), 32'(v.exp_pc));
      chk($sformatf("vec%0d instr", idx), 32'(bus.instr), 32'(v.exp_instr));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0;
    #1;
  endtask

  task automatic cyc(logic rdy, logic rv, logic [15:0] ra);
    @(negedge clk);
    rst = 1'b0;
    bus.instr_ready = rdy;
    redirect_valid = rv;
    redirect_addr = ra;
    #1;
  endtask

  initial begin
    int n;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    bus.instr_ready = 1'b1;

    // Streaming with zero-wait memory, decode always ready.
    tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 1, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 1, 16'h0000, 16'hFFFF));
    tbl.push_back(mk(0, 1, 0, 1, 16'h0001, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 1, 16'h0001, 16'hFFFE));
    tbl.push_back(mk(0, 1, 0, 1, 16'h0002, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 1, 16'h0002, 16'hFFFD));
    tbl.push_back(mk(0, 1, 0, 1, 16'h0003, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 1, 16'h0003, 16'hFFFC));
    // Backpressure: buffer fills with two words, then drains in order.
    tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 1, 16'h0000, 16'hFFFF));
    tbl.push_back(mk(0, 0, 0, 1, 16'h0001, 1, 16'h0000, 16'hFFFF));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'hFFFF));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'h0000, 16'hFFFF));
    tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 1, 16'h0001, 16'hFFFE));
    tbl.push_back(mk(0, 1, 0, 1, 16'h0002, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 1, 16'h0002, 16'hFFFD));

    foreach (tbl[i]) run_vec(tbl[i], i);

    // Three wait states: request held stable, exactly one word delivered.
    mem_delay = 3;
    do_reset();
    cyc(1, 0, 0);
    chk("t3 issue pc_inc", 32'(pc_inc), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0);
      chk($sformatf("t3 wait%0d mem_req", i), 32'(bus.mem_req), 32'd1);
      chk($sformatf("t3 wait%0d mem_addr", i), 32'(bus.mem_addr), 32'h0000);
      chk($sformatf("t3 wait%0d instr_valid", i), 32'(bus.instr_valid), 32'd0);
    end
    cyc(1, 0, 0);
    chk("t3 ack cycle state", 32'(state), 32'(REQ));
    cyc(1, 0, 0);
    chk("t3 delivered valid", 32'(bus.instr_valid), 32'd1);
    chk("t3 delivered instr_pc", 32'(bus.instr_pc), 32'h0000);
    chk("t3 delivered instr", 32'(bus.instr), 32'hFFFF);
    chk("t3 mem_req dropped", 32'(bus.mem_req), 32'd0);
    cyc(1, 0, 0);
    chk("t3 single push", 32'(bus.instr_valid), 32'd0);
    chk("t3 next addr", 32'(bus.mem_addr), 32'h0001);

    // Redirect while a request is outstanding; late response must be dropped.
    mem_delay = 0;
    do_reset();
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("t4 buffered valid", 32'(bus.instr_valid), 32'd1);
    mem_delay = 2;
    cyc(0, 1, 16'hDEAD);
    chk("t4 pc_we", 32'(pc_we), 32'd1);
    chk("t4 pc_data", 32'(pc_data), 32'hDEAD);
    chk("t4 no pc_inc", 32'(pc_inc), 32'd0);
    chk("t4 req outstanding", 32'(bus.mem_req), 32'd1);
    cyc(0, 0, 0);
    chk("t4 flushed", 32'(bus.instr_valid), 32'd0);
    chk("t4 discard state", 32'(state), 32'(DISCARD));
    chk("t4 pc_we low", 32'(pc_we), 32'd0);
    cyc(0, 0, 0);
    chk("t4 late ack state", 32'(state), 32'(DISCARD));
    cyc(1, 0, 0);
    chk("t4 back to idle", 32'(state), 32'(IDLE));
    chk("t4 late data dropped", 32'(bus.instr_valid), 32'd0);
    chk("t4 reissue pc_inc", 32'(pc_inc), 32'd1);
    chk("t4 pc loaded", 32'(pc_count), 32'hDEAD);
    cyc(1, 0, 0);
    chk("t4 new mem_addr", 32'(bus.mem_addr), 32'hDEAD);
    n = 0;
    do begin
      cyc(1, 0, 0);
      n++;
    end while (!bus.instr_valid && n < 10);
    chk("t4 delivery timeout", 32'(bus.instr_valid), 32'd1);
    chk("t4 first instr_pc", 32'(bus.instr_pc), 32'hDEAD);
    chk("t4 first instr", 32'(bus.instr), 32'h2152);

    // Redirect coinciding with an ack and a pop.
    mem_delay = 0;
    do_reset();
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 1, 16'h1234);
    chk("t5 valid at pop", 32'(bus.instr_valid), 32'd1);
    chk("t5 ack cycle req", 32'(bus.mem_req), 32'd1);
    chk("t5 pc_we", 32'(pc_we), 32'd1);
    cyc(0, 0, 0);
    chk("t5 no push", 32'(bus.instr_valid), 32'd0);
    chk("t5 idle", 32'(state), 32'(IDLE));
    chk("t5 pc_inc", 32'(pc_inc), 32'd1);
    chk("t5 pc loaded", 32'(pc_count), 32'h1234);
    cyc(0, 0, 0);
    chk("t5 new mem_addr", 32'(bus.mem_addr), 32'h1234);
    cyc(0, 0, 0);
    chk("t5 first instr_pc", 32'(bus.instr_pc), 32'h1234);
    chk("t5 first instr", 32'(bus.instr), 32'hEDCB);

    // Asynchronous reset with a request outstanding and a buffered word.
    mem_delay = 0;
    do_reset();
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    mem_delay = 3;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("t6 pre-reset req", 32'(bus.mem_req), 32'd1);
    chk("t6 pre-reset valid", 32'(bus.instr_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6 async mem_req", 32'(bus.mem_req), 32'd0);
    chk("t6 async instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("t6 async instr", 32'(bus.instr), 32'h0000);
    chk("t6 async instr_pc", 32'(bus.instr_pc), 32'h0000);
    chk("t6 async pc_inc", 32'(pc_inc), 32'd0);
    mem_delay = 0;
    cyc(1, 0, 0);
    chk("t6 restart pc_inc", 32'(pc_inc), 32'd1);
    chk("t6 restart pc", 32'(pc_count), 32'h0000);
    cyc(1, 0, 0);
    chk("t6 restart req", 32'(bus.mem_req), 32'd1);
    chk("t6 restart addr", 32'(bus.mem_addr), 32'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
